rdi_pm_entry_ctrl: RTL and testbench

RDI power-management entry/exit controller on the physical-layer side of the Raw Die-to-Die Interface. It receives the adapter's L1/L2 state requests and starts the stall handshake stage by asserting `o_stall_start`. It waits for that stage's `o_stall_done`, then runs the sideband request/response exchange with the remote die and drives the resulting RDI state status. It sits directly upstream of the stall handshake block and shares its state and message encodings.

---
 rtl/rdi_pm_entry_ctrl.sv | 159 +++++++++++++++
 tb/tb_rdi_pm_entry_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rdi_pm_entry_ctrl.sv
// RDI power-management entry/exit controller: L1/L2 requests go through the stall
// handshake, then a sideband request/response with the remote die sets the state status.
module rdi_pm_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       lclk,
  input  logic       sys_rst,
  input  logic [3:0] i_lp_state_req,
  input  logic [3:0] i_rx_sb_message,
  input  logic       i_rx_sb_message_valid,
  input  logic       i_pl_error,
  input  logic       i_stall_done,
  input  logic       i_tx_sb_ready,
  output logic       o_stall_start,
  output logic [3:0] o_tx_sb_message,
  output logic       o_tx_sb_valid,
  output logic [3:0] o_pl_state_sts,
  output logic       o_busy
);

  // state     | meaning
  // ST_NOP    | out of reset, waiting for Active request
  // ST_ACTIVE | link active (or ActivePMNAK), accepts L1/L2 requests
  // ST_STALL  | stall handshake in progress
  // ST_REQ    | sending L1_REQ/L2_REQ
  // ST_WAIT   | waiting for L1_RSP/L2_RSP or PM NAK
  // ST_PM     | in L1 or L2
  // ST_XREQ   | sending ACTIVE_REQ
  // ST_XWAIT  | waiting for ACTIVE_RSP
  // ST_ERR    | LinkError, sticky until reset
  typedef enum logic [3:0] {
    ST_NOP, ST_ACTIVE, ST_STALL, ST_REQ, ST_WAIT, ST_PM, ST_XREQ, ST_XWAIT, ST_ERR
  } state_t;

  localparam logic [3:0] REQ_ACTIVE   = 4'b0001;
  localparam logic [3:0] REQ_L1       = 4'b0100;
  localparam logic [3:0] REQ_L2       = 4'b1000;
  localparam logic [3:0] STS_NOP      = 4'b0000;
  localparam logic [3:0] STS_ACTIVE   = 4'b0001;
  localparam logic [3:0] STS_PMNAK    = 4'b0010;
  localparam logic [3:0] STS_L1       = 4'b0100;
  localparam logic [3:0] STS_L2       = 4'b1000;
  localparam logic [3:0] STS_LINKERR  = 4'b1010;
  localparam logic [3:0] MSG_ACT_REQ  = 4'd1;
  localparam logic [3:0] MSG_ACT_RSP  = 4'd2;
  localparam logic [3:0] MSG_L1_REQ   = 4'd3;
  localparam logic [3:0] MSG_L1_RSP   = 4'd4;
  localparam logic [3:0] MSG_L2_REQ   = 4'd5;
  localparam logic [3:0] MSG_L2_RSP   = 4'd6;
  localparam logic [3:0] MSG_PM_NAK   = 4'd15;
  localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        target_l2;
  logic [15:0] cnt;
  logic        pm_rsp_match;

  assign pm_rsp_match = i_rx_sb_message_valid &&
                        ((i_rx_sb_message == MSG_L1_RSP && !target_l2) ||
                         (i_rx_sb_message == MSG_L2_RSP &&  target_l2));

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state           <= ST_NOP;
      target_l2       <= 1'b0;
      cnt             <= 16'd0;
      o_stall_start   <= 1'b0;
      o_tx_sb_message <= 4'd0;
      o_tx_sb_valid   <= 1'b0;
      o_pl_state_sts  <= STS_NOP;
      o_busy          <= 1'b0;
    end else if (i_pl_error) begin
      state          <= ST_ERR;
      o_pl_state_sts <= STS_LINKERR;
      o_stall_start  <= 1'b0;
      o_tx_sb_valid  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      case (state)
        ST_NOP: begin
          if (i_lp_state_req == REQ_ACTIVE) begin
            o_pl_state_sts <= STS_ACTIVE;
            state          <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // After a NAK the adapter must re-request Active before another PM attempt
          if (o_pl_state_sts == STS_PMNAK) begin
            if (i_lp_state_req == REQ_ACTIVE) o_pl_state_sts <= STS_ACTIVE;
          end else if (i_lp_state_req == REQ_L1 || i_lp_state_req == REQ_L2) begin
            target_l2     <= (i_lp_state_req == REQ_L2);
            o_stall_start <= 1'b1;
            o_busy        <= 1'b1;
            state         <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (i_stall_done) begin
            o_stall_start   <= 1'b0;
            o_tx_sb_valid   <= 1'b1;
            o_tx_sb_message <= target_l2 ? MSG_L2_REQ : MSG_L1_REQ;
            state           <= ST_REQ;
          end
        end
        ST_REQ, ST_XREQ: begin
          if (i_tx_sb_ready) begin
            o_tx_sb_valid <= 1'b0;
            cnt           <= 16'd0;
            state         <= (state == ST_REQ) ? ST_WAIT : ST_XWAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
          if (pm_rsp_match) begin
            o_pl_state_sts <= target_l2 ? STS_L2 : STS_L1;
            o_busy         <= 1'b0;
            state          <= ST_PM;
          end else if (i_rx_sb_message_valid && i_rx_sb_message == MSG_PM_NAK) begin
            o_pl_state_sts <= STS_PMNAK;
            o_busy         <= 1'b0;
            state          <= ST_ACTIVE;
          end else if (cnt == CNT_LAST) begin
            o_pl_state_sts <= STS_LINKERR;
            o_busy         <= 1'b0;
            state          <= ST_ERR;
          end
        end
        ST_PM: begin
          if (i_lp_state_req == REQ_ACTIVE) begin
            o_tx_sb_valid   <= 1'b1;
            o_tx_sb_message <= MSG_ACT_REQ;
            o_busy          <= 1'b1;
            state           <= ST_XREQ;
          end
        end
        ST_XWAIT: begin
          if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
          if (i_rx_sb_message_valid && i_rx_sb_message == MSG_ACT_RSP) begin
            o_pl_state_sts <= STS_ACTIVE;
            o_busy         <= 1'b0;
            state          <= ST_ACTIVE;
          end else if (cnt == CNT_LAST) begin
            o_pl_state_sts <= STS_LINKERR;
            o_busy         <= 1'b0;
            state          <= ST_ERR;
          end
        end
        default: begin
          o_pl_state_sts <= STS_LINKERR;
          o_stall_start  <= 1'b0;
          o_tx_sb_valid  <= 1'b0;
          o_busy         <= 1'b0;
          state          <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdi_pm_entry_ctrl.sv
// Scoreboard bench for rdi_pm_entry_ctrl: stimulus pushes expected tx messages, status
// changes (with cycle) and stall pulse widths; a negedge monitor pops and compares.
module tb_rdi_pm_entry_ctrl;
  logic       lclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] lp_state_req = 4'd0;
  logic [3:0] rx_sb_message = 4'd0;
  logic       rx_sb_message_valid = 1'b0;
  logic       pl_error = 1'b0;
  logic       stall_done = 1'b0;
  logic       tx_sb_ready = 1'b0;
  logic       stall_start;
  logic [3:0] tx_sb_message;
  logic       tx_sb_valid;
  logic [3:0] pl_state_sts;
  logic       busy;

  rdi_pm_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .lclk(lclk), .sys_rst(sys_rst),
    .i_lp_state_req(lp_state_req), .i_rx_sb_message(rx_sb_message),
    .i_rx_sb_message_valid(rx_sb_message_valid), .i_pl_error(pl_error),
    .i_stall_done(stall_done), .i_tx_sb_ready(tx_sb_ready),
    .o_stall_start(stall_start), .o_tx_sb_message(tx_sb_message),
    .o_tx_sb_valid(tx_sb_valid), .o_pl_state_sts(pl_state_sts), .o_busy(busy)
  );

  always #5 lclk = ~lclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge lclk) cyc <= cyc + 1;

  typedef struct { logic [3:0] sts; int at; } sts_exp_t;
  sts_exp_t   sts_q[$];
  logic [3:0] tx_q[$];
  int         stall_q[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge lclk);
      #1;
    end
  endtask

  logic [3:0] prev_sts = 4'd0;
  int         stall_len = 0;
  always @(negedge lclk) begin
    if (tx_sb_valid) begin
      if (tx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected: got msg %0d expected no valid (cycle %0d)", tx_sb_message, cyc);
      end else check("tx_msg", tx_sb_message, tx_q.pop_front());
    end
    if (pl_state_sts != prev_sts) begin
      if (sts_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sts_unexpected: got %0d expected %0d (cycle %0d)", pl_state_sts, prev_sts, cyc);
      end else begin
        sts_exp_t e;
        e = sts_q.pop_front();
        check("sts_val", pl_state_sts, e.sts);
        check("sts_cycle", cyc, e.at);
      end
      prev_sts = pl_state_sts;
    end
    if (stall_start) stall_len++;
    else if (stall_len != 0) begin
      if (stall_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stall_unexpected: got width %0d expected none", stall_len);
      end else check("stall_width", stall_len, stall_q.pop_front());
      stall_len = 0;
    end
  end

  task automatic check_idle(string tag);
    check({tag, "_stall"}, stall_start, 0);
    check({tag, "_valid"}, tx_sb_valid, 0);
    check({tag, "_msg"}, tx_sb_message, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sts"}, pl_state_sts, 0);
  endtask

  initial begin
    int k;
    #1 sys_rst = 1'b0;
    tick(3);
    check_idle("reset");
    sys_rst = 1'b1;
    tick(2);

    // L1 entry
    k = cyc;
    lp_state_req = 4'b0001; sts_q.push_back('{4'b0001, k + 1});
    tick; lp_state_req = 4'b0100; tx_sb_ready = 1'b1;
    tick; lp_state_req = 4'd0; stall_q.push_back(5); tx_q.push_back(4'd3);
    tick(4); stall_done = 1'b1;
    tick; stall_done = 1'b0;
    tick; check("wait_busy", busy, 1);
    tick(3); rx_sb_message = 4'd2; rx_sb_message_valid = 1'b1;
    tick; rx_sb_message_valid = 1'b0;
    tick(5); rx_sb_message = 4'd4; rx_sb_message_valid = 1'b1;
    sts_q.push_back('{4'b0100, cyc + 1});
    tick; rx_sb_message_valid = 1'b0;
    check("pm_busy", busy, 0);

    // exit from L1 with backpressure
    tick(2); k = cyc;
    tx_sb_ready = 1'b0; lp_state_req = 4'b0001;
    repeat (5) tx_q.push_back(4'd1);
    tick; lp_state_req = 4'd0;
    tick(4); tx_sb_ready = 1'b1;
    tick; rx_sb_message = 4'd2; rx_sb_message_valid = 1'b1;
    sts_q.push_back('{4'b0001, k + 7});
    tick; rx_sb_message_valid = 1'b0;

    // L2 entry refused by PM NAK
    tick(2); k = cyc;
    lp_state_req = 4'b1000; stall_q.push_back(2); tx_q.push_back(4'd5);
    tick; lp_state_req = 4'b0100;
    tick; stall_done = 1'b1; lp_state_req = 4'd0;
    tick; stall_done = 1'b0;
    tick; rx_sb_message = 4'd4; rx_sb_message_valid = 1'b1;
    tick; rx_sb_message = 4'd15;
    sts_q.push_back('{4'b0010, k + 6});
    tick; rx_sb_message_valid = 1'b0; lp_state_req = 4'b0100;
    tick(3);
    check("nak_l1_stall", stall_start, 0);
    check("nak_l1_busy", busy, 0);
    lp_state_req = 4'b0001; sts_q.push_back('{4'b0001, cyc + 1});
    tick; lp_state_req = 4'd0;

    // response timeout
    tick(2); k = cyc;
    lp_state_req = 4'b0100; stall_q.push_back(1); tx_q.push_back(4'd3);
    sts_q.push_back('{4'b1010, k + 19});
    tick; lp_state_req = 4'd0; stall_done = 1'b1;
    tick; stall_done = 1'b0;
    tick(12); check("timeout_pending_busy", busy, 1);
    tick(10); rx_sb_message = 4'd2; rx_sb_message_valid = 1'b1; lp_state_req = 4'b0001;
    tick; rx_sb_message_valid = 1'b0; lp_state_req = 4'd0;
    tick(3);
    check("err_sticky_sts", pl_state_sts, 4'b1010);
    check("err_stall", stall_start, 0);
    check("err_valid", tx_sb_valid, 0);

    // error beats a same-cycle response
    sys_rst = 1'b0; sts_q.push_back('{4'b0000, cyc});
    #1 check_idle("rst_from_err");
    tick; sys_rst = 1'b1;
    tick; k = cyc;
    lp_state_req = 4'b0001; sts_q.push_back('{4'b0001, k + 1});
    tick; lp_state_req = 4'b0100; stall_q.push_back(1); tx_q.push_back(4'd3);
    tick; lp_state_req = 4'd0; stall_done = 1'b1;
    tick; stall_done = 1'b0;
    tick; rx_sb_message = 4'd4; rx_sb_message_valid = 1'b1; pl_error = 1'b1;
    sts_q.push_back('{4'b1010, k + 5});
    tick; rx_sb_message_valid = 1'b0; pl_error = 1'b0;
    tick(2);
    sys_rst = 1'b0; sts_q.push_back('{4'b0000, cyc});
    tick; sys_rst = 1'b1;

    // reset in the middle of the stall handshake
    tick; k = cyc;
    lp_state_req = 4'b0001; sts_q.push_back('{4'b0001, k + 1});
    tick; lp_state_req = 4'b0100; stall_q.push_back(2);
    tick; lp_state_req = 4'd0;
    tick; check("stall_busy", busy, 1);
    tick; sys_rst = 1'b0; sts_q.push_back('{4'b0000, cyc});
    #1 check_idle("rst_mid_stall");
    tick(2); sys_rst = 1'b1;
    tick(3);

    check("tx_q_drained", tx_q.size(), 0);
    check("sts_q_drained", sts_q.size(), 0);
    check("stall_q_drained", stall_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
